// File: rtl/wb_counter_core.sv
// rtl/wb_counter_core.sv - Wishbone-mapped prescaled up/down counter with limit, wrap flag and irq.
// Register window: CTRL, COUNT, LIMIT, STATUS at BASE_ADDR + 0x0/0x4/0x8/0xC.
module wb_counter_core #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter logic [31:0] RESET_LIMIT = 32'hFFFF_FFFF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [15:0] io_out,
  output logic [15:0] io_oeb,
  output logic        irq
);

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_COUNT  = 2'd1;
  localparam logic [1:0] REG_LIMIT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  // Bus-side state
  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;
  logic        wr_pend_q, wr_pend_d;
  logic [1:0]  wr_idx_q, wr_idx_d;
  logic [31:0] wr_dat_q, wr_dat_d;
  logic [3:0]  wr_sel_q, wr_sel_d;

  // Counter-side state
  logic        en_q, en_d;
  logic        dir_q, dir_d;
  logic        irq_en_q, irq_en_d;
  logic [7:0]  presc_q, presc_d;
  logic [7:0]  pcnt_q, pcnt_d;
  logic [31:0] count_q, count_d;
  logic [31:0] limit_q, limit_d;
  logic        wrap_q, wrap_d;

  logic        req, hit, accept;
  logic [31:0] ctrl_rd, status_rd, ctrl_new;
  logic        wr_ctrl, wr_count, wr_limit, wr_status;
  logic        tick, wrap_set, wrap_clr;
  logic        unused_ok;

  assign ctrl_rd   = {16'h0, presc_q, 5'h0, irq_en_q, dir_q, en_q};
  assign status_rd = {30'h0, en_q, wrap_q};

  always_comb begin
    req       = wbs_cyc_i & wbs_stb_i;
    hit       = req && (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    accept    = req && !ack_q;
    ack_d     = accept;
    wr_pend_d = accept && hit && wbs_we_i;
    wr_idx_d  = accept ? wbs_adr_i[3:2] : wr_idx_q;
    wr_dat_d  = accept ? wbs_dat_i : wr_dat_q;
    wr_sel_d  = accept ? wbs_sel_i : wr_sel_q;
    rdata_d   = 32'h0;
    if (accept && hit && !wbs_we_i) begin
      case (wbs_adr_i[3:2])
        REG_CTRL:   rdata_d = ctrl_rd;
        REG_COUNT:  rdata_d = count_q;
        REG_LIMIT:  rdata_d = limit_q;
        default:    rdata_d = status_rd;
      endcase
    end
  end

  // A write is latched at acceptance and commits at the edge closing the ack cycle.
  always_comb begin
    wr_ctrl   = wr_pend_q && (wr_idx_q == REG_CTRL);
    wr_count  = wr_pend_q && (wr_idx_q == REG_COUNT);
    wr_limit  = wr_pend_q && (wr_idx_q == REG_LIMIT);
    wr_status = wr_pend_q && (wr_idx_q == REG_STATUS);
    ctrl_new  = byte_merge(ctrl_rd, wr_dat_q, wr_sel_q);
    tick      = en_q && (pcnt_q == presc_q);

    en_d     = en_q;
    dir_d    = dir_q;
    irq_en_d = irq_en_q;
    presc_d  = presc_q;
    count_d  = count_q;
    limit_d  = limit_q;
    wrap_set = 1'b0;

    if (tick || !en_q) pcnt_d = 8'd0;
    else               pcnt_d = pcnt_q + 8'd1;

    if (wr_count) begin
      count_d = byte_merge(count_q, wr_dat_q, wr_sel_q);
    end else if (tick) begin
      if (!dir_q) begin
        if (count_q == limit_q) begin
          count_d  = 32'h0;
          wrap_set = 1'b1;
        end else begin
          count_d = count_q + 32'd1;
        end
      end else begin
        if (count_q == 32'h0) begin
          count_d  = limit_q;
          wrap_set = 1'b1;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
    end

    if (wr_ctrl) begin
      en_d     = ctrl_new[0];
      dir_d    = ctrl_new[1];
      irq_en_d = ctrl_new[2];
      presc_d  = ctrl_new[15:8];
      if ((en_d != en_q) || (presc_d != presc_q)) pcnt_d = 8'd0;
    end

    if (wr_limit) limit_d = byte_merge(limit_q, wr_dat_q, wr_sel_q);

    wrap_clr = wr_status && wr_sel_q[0] && wr_dat_q[0];
    wrap_d   = wrap_set ? 1'b1 : (wrap_clr ? 1'b0 : wrap_q);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      ack_q     <= 1'b0;
      rdata_q   <= 32'h0;
      wr_pend_q <= 1'b0;
      wr_idx_q  <= 2'd0;
      wr_dat_q  <= 32'h0;
      wr_sel_q  <= 4'h0;
      en_q      <= 1'b0;
      dir_q     <= 1'b0;
      irq_en_q  <= 1'b0;
      presc_q   <= 8'h0;
      pcnt_q    <= 8'h0;
      count_q   <= 32'h0;
      limit_q   <= RESET_LIMIT;
      wrap_q    <= 1'b0;
    end else begin
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      wr_pend_q <= wr_pend_d;
      wr_idx_q  <= wr_idx_d;
      wr_dat_q  <= wr_dat_d;
      wr_sel_q  <= wr_sel_d;
      en_q      <= en_d;
      dir_q     <= dir_d;
      irq_en_q  <= irq_en_d;
      presc_q   <= presc_d;
      pcnt_q    <= pcnt_d;
      count_q   <= count_d;
      limit_q   <= limit_d;
      wrap_q    <= wrap_d;
    end
  end

  assign unused_ok = ^{ctrl_new[31:16], ctrl_new[7:3], wbs_adr_i[1:0]};

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rdata_q;
  assign io_out    = count_q[15:0];
  assign io_oeb    = 16'h0000;
  assign irq       = wrap_q & irq_en_q;

endmodule

// File: tb/tb_wb_counter_core.sv
// tb/tb_wb_counter_core.sv - self-checking bench for wb_counter_core.
// A cycle model of the register map runs alongside the DUT; directed tests add literal checks.
module tb_wb_counter_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0, dat_w = 32'h0;
  logic        ack;
  logic [31:0] dat_r;
  logic [15:0] io_out, io_oeb;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_counter_core dut (
    .wb_clk_i (clk),
    .wb_rst_n (rst_n),
    .wbs_cyc_i(cyc),
    .wbs_stb_i(stb),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(dat_w),
    .wbs_ack_o(ack),
    .wbs_dat_o(dat_r),
    .io_out   (io_out),
    .io_oeb   (io_oeb),
    .irq      (irq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: registers as plain 32-bit words, prescaler phase as an int.
  logic [31:0] m_ctrl, m_count, m_limit, m_rdata, m_padr, m_pdat;
  logic        m_wrap, m_ack, m_pend;
  logic [3:0]  m_psel;
  int          m_phase;

  function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [31:0] nv,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nv[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic        fire, nwrap, running;
    logic [31:0] nctrl, ncount, nlimit, word;
    int          nphase, presc;
    if (!rst_n) begin
      m_ctrl = 0; m_count = 0; m_limit = 32'hFFFF_FFFF; m_wrap = 0; m_phase = 0;
      m_ack = 0; m_rdata = 0; m_pend = 0; m_padr = 0; m_pdat = 0; m_psel = 0;
    end else begin
      running = m_ctrl[0];
      presc   = int'(m_ctrl[15:8]);
      fire    = running && (m_phase == presc);
      nphase  = (running && !fire) ? m_phase + 1 : 0;
      nctrl = m_ctrl; ncount = m_count; nlimit = m_limit; nwrap = m_wrap;
      if (fire) begin
        if (m_ctrl[1] == 1'b0) begin
          if (m_count == m_limit) begin ncount = 0; nwrap = 1; end
          else ncount = m_count + 1;
        end else begin
          if (m_count == 0) begin ncount = m_limit; nwrap = 1; end
          else ncount = m_count - 1;
        end
      end
      if (m_pend) begin
        case (m_padr[3:2])
          2'd0: begin
            nctrl = lanes(m_ctrl, m_pdat, m_psel) & 32'h0000_FF07;
            if (nctrl[0] != m_ctrl[0] || nctrl[15:8] != m_ctrl[15:8]) nphase = 0;
          end
          2'd1: begin
            ncount = lanes(m_count, m_pdat, m_psel);
            nwrap  = m_wrap;
            nphase = 0;
          end
          2'd2: nlimit = lanes(m_limit, m_pdat, m_psel);
          default: if (m_psel[0] && m_pdat[0] && !(fire && nwrap && !m_wrap)) nwrap = 0;
        endcase
      end
      m_rdata = 0;
      m_pend  = 0;
      if (cyc && stb && !m_ack) begin
        if (adr[31:4] == 28'h300_0000) begin
          if (we) begin
            m_pend = 1; m_padr = adr; m_pdat = dat_w; m_psel = sel;
          end else begin
            case (adr[3:2])
              2'd0: word = m_ctrl;
              2'd1: word = m_count;
              2'd2: word = m_limit;
              default: word = {30'h0, m_ctrl[0], m_wrap};
            endcase
            m_rdata = word;
          end
        end
        m_ack = 1;
      end else begin
        m_ack = 0;
      end
      m_ctrl = nctrl; m_count = ncount; m_limit = nlimit; m_wrap = nwrap; m_phase = nphase;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("m_io_out", {16'h0, io_out}, {16'h0, m_count[15:0]});
      chk("m_irq", {31'h0, irq}, {31'h0, m_wrap & m_ctrl[2]});
      chk("m_io_oeb", {16'h0, io_oeb}, 32'h0);
      chk("m_ack", {31'h0, ack}, {31'h0, m_ack});
      chk("m_dat_o", dat_r, m_rdata);
    end
  end

  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd);
    @(negedge clk);
    cyc = 1; stb = 1; we = w; adr = a; dat_w = d; sel = s;
    @(negedge clk);
    chk("ack_one_cycle", {31'h0, ack}, 32'h1);
    rd = dat_r;
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] junk;
    xfer(a, 1'b1, d, s, junk);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    xfer(a, 1'b0, 32'h0, 4'hF, v);
    chk(name, v, exp);
  endtask

  localparam logic [31:0] A_CTRL = 32'h3000_0000, A_CNT = 32'h3000_0004;
  localparam logic [31:0] A_LIM  = 32'h3000_0008, A_STAT = 32'h3000_000C;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [15:0] seq[5];
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'h0, ack}, 32'h0);
    chk("rst_dat", dat_r, 32'h0);
    chk("rst_io_out", {16'h0, io_out}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    rst_n = 1;

    rd_chk("rd_ctrl_rst", A_CTRL, 32'h0);
    rd_chk("rd_count_rst", A_CNT, 32'h0);
    rd_chk("rd_limit_rst", A_LIM, 32'hFFFF_FFFF);
    rd_chk("rd_status_rst", A_STAT, 32'h0);

    // Up count to LIMIT=3 with prescaler 0
    wr(A_LIM, 32'd3, 4'hF);
    wr(A_CTRL, 32'h1, 4'hF);
    seq[0] = 0; seq[1] = 1; seq[2] = 2; seq[3] = 3; seq[4] = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("up_seq%0d", i), {16'h0, io_out}, {16'h0, seq[i]});
    end
    chk("up_irq_off", {31'h0, irq}, 32'h0);
    rd_chk("up_status", A_STAT, 32'h3);
    wr(A_CTRL, 32'h0, 4'hF);
    wr(A_STAT, 32'h1, 4'hF);
    rd_chk("w1c_status", A_STAT, 32'h0);

    // Down count, PRESC=4, IRQ enabled
    wr(A_LIM, 32'd2, 4'hF);
    wr(A_CNT, 32'd0, 4'hF);
    wr(A_CTRL, 32'h0000_0407, 4'hF);
    repeat (6) @(negedge clk);
    chk("dn_count", {16'h0, io_out}, 32'h2);
    chk("dn_irq", {31'h0, irq}, 32'h1);
    wr(A_STAT, 32'h1, 4'hF);
    @(negedge clk);
    chk("dn_irq_clr", {31'h0, irq}, 32'h0);
    wr(A_CTRL, 32'h0, 4'hF);

    // COUNT write colliding with a tick, partial byte lanes
    wr(A_CTRL, 32'h1, 4'hF);
    wr(A_CNT, 32'hABCD_1234, 4'b0011);
    @(negedge clk);
    chk("col_cnt0", {16'h0, io_out}, 32'h1234);
    @(negedge clk);
    chk("col_cnt1", {16'h0, io_out}, 32'h1235);
    rd_chk("col_rd", A_CNT, 32'h0000_1236);
    wr(A_CTRL, 32'h0, 4'hF);

    // Out-of-window accesses
    wr(32'h3000_0010, 32'hDEAD_BEEF, 4'hF);
    rd_chk("miss_rd", 32'h3100_0000, 32'h0);
    rd_chk("miss_ctrl", A_CTRL, 32'h0);
    rd_chk("miss_limit", A_LIM, 32'h2);

    // 32-bit rollover above LIMIT does not set WRAP
    wr(A_STAT, 32'h1, 4'hF);
    wr(A_LIM, 32'h10, 4'hF);
    wr(A_CNT, 32'hFFFF_FFFE, 4'hF);
    wr(A_CTRL, 32'h1, 4'hF);
    @(negedge clk); chk("roll0", {16'h0, io_out}, 32'hFFFE);
    @(negedge clk); chk("roll1", {16'h0, io_out}, 32'hFFFF);
    @(negedge clk); chk("roll2", {16'h0, io_out}, 32'h0);
    rd_chk("roll_status", A_STAT, 32'h2);
    wr(A_CTRL, 32'h0, 4'hF);

    // Reset during a write's ack cycle
    wr(A_CNT, 32'd5, 4'hF);
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; adr = A_CNT; dat_w = 32'h99; sel = 4'hF;
    @(negedge clk);
    chk("rst_mid_ack", {31'h0, ack}, 32'h1);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_ack_drop", {31'h0, ack}, 32'h0);
    chk("rst_mid_io_out", {16'h0, io_out}, 32'h0);
    cyc = 0; stb = 0; we = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    rd_chk("post_rst_count", A_CNT, 32'h0);
    rd_chk("post_rst_limit", A_LIM, 32'hFFFF_FFFF);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
